// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing recovery: locks onto active-low h/v sync, rebuilds the pixel
// position in the same cycle as the source, and reports sync edges that break the timing.
module vga_sync_rx #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned LOCK_LINES  = 2,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_h_sync,
  input  logic                        i_v_sync,
  output logic                        o_locked,
  output logic                        o_draw_active,
  output logic [$clog2(H_ACTIVE)-1:0] o_active_x,
  output logic [$clog2(V_ACTIVE)-1:0] o_active_y,
  output logic                        o_frame_start,
  output logic                        o_h_err,
  output logic                        o_v_err,
  output logic [7:0]                  o_err_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS0     = H_ACTIVE + H_FRONT;
  localparam int unsigned HS1     = HS0 + H_SYNC;
  localparam int unsigned VS0     = V_ACTIVE + V_FRONT;
  localparam int unsigned VS1     = VS0 + V_SYNC;

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);
  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);
  localparam int unsigned LW = $clog2(LOCK_LINES + 1);
  localparam int unsigned FW = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0] HLast     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActive   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HSyncBeg  = HW'(HS0);
  localparam logic [HW-1:0] HSyncNext = HW'(HS0 + 1);
  localparam logic [HW-1:0] HSyncEnd  = HW'(HS1);
  localparam logic [VW-1:0] VLast     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActive   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VSyncBeg  = VW'(VS0);
  localparam logic [VW-1:0] VSyncEnd  = VW'(VS1);
  localparam logic [LW-1:0] LockLines  = LW'(LOCK_LINES);
  localparam logic [FW-1:0] LockFrames = FW'(LOCK_FRAMES);

  typedef enum logic [2:0] {
    StAcqH,
    StChkH,
    StAcqV,
    StChkV,
    StLocked
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [LW-1:0] lines_q, lines_d;
  logic [FW-1:0] frames_q, frames_d;
  logic          h_q, v_q;
  logic          h_err_q, h_err_d;
  logic          v_err_q, v_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic h_fall, h_rise, v_fall, v_rise;
  logic h_at_fall, h_at_rise, v_at_fall, v_at_rise;
  logic h_viol, v_viol;
  logic h_wrap, v_wrap;
  logic [LW-1:0] lines_inc;
  logic [FW-1:0] frames_inc;
  logic locked;

  // Edge detection and expected-edge positions.
  always_comb begin
    h_fall    = h_q & ~i_h_sync;
    h_rise    = ~h_q & i_h_sync;
    v_fall    = v_q & ~i_v_sync;
    v_rise    = ~v_q & i_v_sync;
    h_at_fall = (h_cnt_q == HSyncBeg);
    h_at_rise = (h_cnt_q == HSyncEnd);
    v_at_fall = (h_cnt_q == '0) && (v_cnt_q == VSyncBeg);
    v_at_rise = (h_cnt_q == '0) && (v_cnt_q == VSyncEnd);
    h_viol    = (h_fall != h_at_fall) || (h_rise != h_at_rise);
    v_viol    = (v_fall != v_at_fall) || (v_rise != v_at_rise);
    h_wrap    = (h_cnt_q == HLast);
    v_wrap    = (v_cnt_q == VLast);
    lines_inc  = lines_q + LW'(1);
    frames_inc = frames_q + FW'(1);
  end

  // Position counters; outside lock every sync fall snaps them to the source.
  always_comb begin
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
    end
    if (state_q != StLocked) begin
      if (h_fall) begin
        h_cnt_d = HSyncNext;
      end
      if (v_fall) begin
        v_cnt_d = VSyncBeg;
      end
    end
  end

  // Acquisition / lock state machine.
  always_comb begin
    state_d   = state_q;
    lines_d   = lines_q;
    frames_d  = frames_q;
    h_err_d   = 1'b0;
    v_err_d   = 1'b0;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      StAcqH: begin
        if (h_fall) begin
          state_d = StChkH;
          lines_d = '0;
        end
      end
      StChkH: begin
        if (h_fall) begin
          if (h_at_fall) begin
            lines_d = lines_inc;
            if (lines_inc == LockLines) begin
              state_d = StAcqV;
            end
          end else begin
            lines_d = '0;
          end
        end
      end
      StAcqV: begin
        if (v_fall) begin
          if (h_cnt_q == '0) begin
            state_d  = StChkV;
            frames_d = '0;
          end else begin
            state_d = StAcqH;
          end
        end
      end
      StChkV: begin
        if (h_viol) begin
          state_d = StAcqH;
        end else if (v_fall) begin
          if (v_at_fall) begin
            frames_d = frames_inc;
            if (frames_inc == LockFrames) begin
              state_d = StLocked;
            end
          end else begin
            frames_d = '0;
          end
        end
      end
      StLocked: begin
        if (h_viol) begin
          h_err_d = 1'b1;
          v_err_d = v_viol;
          state_d = StAcqH;
        end else if (v_viol) begin
          v_err_d = 1'b1;
          state_d = StAcqV;
        end
        // Simultaneous h and v violations count as a single event.
        if ((h_viol || v_viol) && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: state_d = StAcqH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StAcqH;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      lines_q   <= '0;
      frames_q  <= '0;
      h_q       <= 1'b1;
      v_q       <= 1'b1;
      h_err_q   <= 1'b0;
      v_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      lines_q   <= lines_d;
      frames_q  <= frames_d;
      h_q       <= i_h_sync;
      v_q       <= i_v_sync;
      h_err_q   <= h_err_d;
      v_err_q   <= v_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    locked        = (state_q == StLocked);
    o_locked      = locked;
    o_draw_active = locked && (h_cnt_q < HActive) && (v_cnt_q < VActive);
    o_active_x    = o_draw_active ? h_cnt_q[XW-1:0] : '0;
    o_active_y    = o_draw_active ? v_cnt_q[YW-1:0] : '0;
    o_frame_start = locked && (h_cnt_q == '0) && (v_cnt_q == '0);
    o_h_err       = h_err_q;
    o_v_err       = v_err_q;
    o_err_count   = err_cnt_q;
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx: a scaled-down timing generator drives the receiver, and a
// position-based model predicts lock, coordinates and error pulses every cycle.
module tb_vga_sync_rx;

  localparam int HA = 5, HF = 1, HSY = 2, HB = 2;
  localparam int VA = 3, VF = 1, VSY = 2, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int HS0 = HA + HF, HS1 = HS0 + HSY;
  localparam int VS0 = VA + VF, VS1 = VS0 + VSY;
  localparam int FRAME = HT * VT;
  localparam int LOCK_LINES = 2, LOCK_FRAMES = 2;

  localparam int WaitHFall = 0, CountLines = 1, WaitVFall = 2, CountFrames = 3, Locked = 4;

  logic clk = 1'b0;
  logic rst_n, i_h_sync, i_v_sync;
  logic o_locked, o_draw_active, o_frame_start, o_h_err, o_v_err;
  logic [$clog2(HA)-1:0] o_active_x;
  logic [$clog2(VA)-1:0] o_active_y;
  logic [7:0] o_err_count;

  vga_sync_rx #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .LOCK_LINES(LOCK_LINES), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_h_sync(i_h_sync), .i_v_sync(i_v_sync),
    .o_locked(o_locked), .o_draw_active(o_draw_active),
    .o_active_x(o_active_x), .o_active_y(o_active_y),
    .o_frame_start(o_frame_start), .o_h_err(o_h_err), .o_v_err(o_v_err),
    .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errs = 0;
  int gx, gy, cyc;
  bit sup_h, glitch, stretch_v;
  int m_phase, m_lines, m_frames, m_cnt;
  bit m_herr, m_verr, prev_h, prev_v;
  int herr_seen, verr_seen, fs_seen;
  bit abort_glitches;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at cyc %0d (x=%0d y=%0d): got %0d, want %0d", name, cyc, gx, gy, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = WaitHFall; m_lines = 0; m_frames = 0; m_cnt = 0;
    m_herr = 0; m_verr = 0; prev_h = 1; prev_v = 1;
  endtask

  // Source position equals recovered position in every scenario used here.
  task automatic model_update(input bit h_in, input bit v_in);
    bit hf, hr, vf, vr, hv, vv;
    hf = prev_h && !h_in;
    hr = !prev_h && h_in;
    vf = prev_v && !v_in;
    vr = !prev_v && v_in;
    hv = (hf != (gx == HS0)) || (hr != (gx == HS1));
    vv = (vf != (gx == 0 && gy == VS0)) || (vr != (gx == 0 && gy == VS1));
    m_herr = 0;
    m_verr = 0;
    case (m_phase)
      WaitHFall: if (hf) begin m_phase = CountLines; m_lines = 0; end
      CountLines: if (hf) begin
        if (gx == HS0) begin
          m_lines++;
          if (m_lines == LOCK_LINES) m_phase = WaitVFall;
        end else m_lines = 0;
      end
      WaitVFall: if (vf) begin
        m_phase = (gx == 0) ? CountFrames : WaitHFall;
        m_frames = 0;
      end
      CountFrames: if (hv) m_phase = WaitHFall;
        else if (vf) begin
          if (gx == 0 && gy == VS0) begin
            m_frames++;
            if (m_frames == LOCK_FRAMES) m_phase = Locked;
          end else m_frames = 0;
        end
      default: if (hv || vv) begin
        m_herr = hv;
        m_verr = vv;
        if (m_cnt < 255) m_cnt++;
        m_phase = hv ? WaitHFall : WaitVFall;
      end
    endcase
    prev_h = h_in;
    prev_v = v_in;
  endtask

  // One source cycle: drive, compare against the model, update, advance.
  task automatic step();
    bit h_in, v_in, mlock, exp_draw;
    h_in = !(gx >= HS0 && gx < HS1) || sup_h;
    if (glitch) h_in = 0;
    v_in = !((gy >= VS0 && gy < VS1) || (stretch_v && gy == VS1));
    i_h_sync = h_in;
    i_v_sync = v_in;
    mlock = (m_phase == Locked);
    exp_draw = mlock && gx < HA && gy < VA;
    chk("locked", o_locked, mlock);
    chk("draw_active", o_draw_active, exp_draw);
    chk("active_x", o_active_x, exp_draw ? gx : 0);
    chk("active_y", o_active_y, exp_draw ? gy : 0);
    chk("frame_start", o_frame_start, mlock && gx == 0 && gy == 0);
    chk("h_err", o_h_err, m_herr);
    chk("v_err", o_v_err, m_verr);
    chk("err_count", o_err_count, m_cnt);
    herr_seen += int'(o_h_err === 1'b1);
    verr_seen += int'(o_v_err === 1'b1);
    fs_seen   += int'(o_frame_start === 1'b1);
    if (rst_n) model_update(h_in, v_in);
    else model_reset();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      rst_n = 1; gx = 0; gy = 0; cyc = 0;
    end else begin
      cyc++;
      if (gx == HT - 1) begin
        gx = 0;
        gy = (gy == VT - 1) ? 0 : gy + 1;
      end else gx++;
    end
  endtask

  task automatic run_until_pos(input int x, input int y, input int budget);
    int n = 0;
    while (!(gx == x && gy == y) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      chk("reach_pos_x", gx, x);
      chk("reach_pos_y", gy, y);
    end
  endtask

  task automatic wait_lock(input int budget);
    int n = 0;
    while (o_locked !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("relock", o_locked, 1);
  endtask

  initial begin
    rst_n = 0; i_h_sync = 1; i_v_sync = 1;
    sup_h = 0; glitch = 0; stretch_v = 0; abort_glitches = 0;
    herr_seen = 0; verr_seen = 0; fs_seen = 0;
    gx = 0; gy = 0; cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    chk("rst_locked", o_locked, 0);
    chk("rst_draw", o_draw_active, 0);
    chk("rst_err_count", o_err_count, 0);

    // Initial acquisition: lock lands 2 frames + VS0 lines + 1 cycle after release.
    while (cyc < 180) step();
    chk("lock_cyc180", o_locked, 0);
    step();
    chk("lock_cyc181", o_locked, 1);
    chk("lock_pos_x", gx, 1);
    chk("lock_pos_y", gy, VS0);
    chk("acq_no_err_pulses", herr_seen + verr_seen, 0);

    // Steady state over three frames.
    run_until_pos(0, 0, FRAME);
    chk("frame_start_at_00", o_frame_start, 1);
    fs_seen = 0;
    repeat (3 * FRAME) step();
    chk("frame_starts_3frames", fs_seen, 3);
    run_until_pos(2, 1, FRAME);
    chk("spot_draw", o_draw_active, 1);
    chk("spot_x", o_active_x, 2);
    chk("spot_y", o_active_y, 1);
    run_until_pos(HA, 1, FRAME);
    chk("spot_blank_draw", o_draw_active, 0);

    // One suppressed h sync pulse.
    run_until_pos(0, 0, FRAME);
    herr_seen = 0;
    verr_seen = 0;
    sup_h = 1;
    repeat (HT) step();
    sup_h = 0;
    chk("sup_unlocked", o_locked, 0);
    chk("sup_err_count", o_err_count, 1);
    wait_lock(4 * FRAME);
    chk("sup_relock_x", gx, 1);
    chk("sup_relock_y", gy, VS0);
    chk("sup_herr_pulses", herr_seen, 1);
    chk("sup_verr_pulses", verr_seen, 0);

    // V sync stretched by one line.
    run_until_pos(0, 0, FRAME);
    herr_seen = 0;
    verr_seen = 0;
    stretch_v = 1;
    run_until_pos(1, VS1, FRAME);
    chk("stretch_verr", o_v_err, 1);
    chk("stretch_herr", o_h_err, 0);
    chk("stretch_unlocked", o_locked, 0);
    run_until_pos(0, 0, FRAME);
    stretch_v = 0;
    wait_lock(4 * FRAME);
    chk("stretch_herr_total", herr_seen, 0);
    chk("stretch_verr_total", verr_seen, 1);
    chk("stretch_err_count", o_err_count, 2);

    // One-cycle reset while locked.
    run_until_pos(2, 1, FRAME);
    chk("pre_rst_draw", o_draw_active, 1);
    rst_n = 0;
    step();
    chk("post_rst_locked", o_locked, 0);
    chk("post_rst_draw", o_draw_active, 0);
    chk("post_rst_x", o_active_x, 0);
    chk("post_rst_y", o_active_y, 0);
    chk("post_rst_fs", o_frame_start, 0);
    chk("post_rst_herr", o_h_err, 0);
    chk("post_rst_verr", o_v_err, 0);
    chk("post_rst_err_count", o_err_count, 0);
    while (cyc < 180) step();
    chk("relock_cyc180", o_locked, 0);
    step();
    chk("relock_cyc181", o_locked, 1);

    // Isolated h glitches, each after a full relock; the count must saturate.
    for (int k = 0; k < 300 && !abort_glitches; k++) begin
      wait_lock(4 * FRAME);
      if (o_locked !== 1'b1) abort_glitches = 1;
      else begin
        run_until_pos(2, 5, FRAME);
        glitch = 1;
        step();
        glitch = 0;
        if (k == 253) chk("count_254", o_err_count, 254);
        if (k == 254) chk("count_255", o_err_count, 255);
      end
    end
    repeat (HT) step();
    chk("count_saturated", o_err_count, 255);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
